// File: rtl/upc_lane_arbiter_pkg.sv
// upc_pkg: shared widths, lane index type and FSM state encoding for upc_lane_arbiter
package upc_pkg;
  localparam int UPC_W = 3;
  localparam int NUM_LANES = 2;
  typedef logic lane_t;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t EVAL = 2'd1;
  localparam state_t HOLD = 2'd2;
  localparam state_t DONE = 2'd3;
endpackage

// File: rtl/upc_lane_arbiter_rr.sv
// rr_arbiter_2: two-requester round-robin; pointer names the favoured lane on a tie
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt = (req == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req;
    ptr_d = (advance && |gnt) ? gnt[0] : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/upc_lane_arbiter.sv
// upc_lane_arbiter: shares one UPC decoder/display between two lanes with stolen-item alarms
// Optional per-lane item counters are built when UPC_ITEM_COUNT_EN is defined.
module upc_lane_arbiter
  import upc_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] lane_req,
  input  logic [UPC_W-1:0]     lane_upc0,
  input  logic [UPC_W-1:0]     lane_upc1,
  input  logic [NUM_LANES-1:0] lane_mark,
  input  logic [NUM_LANES-1:0] alarm_ack,
  input  logic                 dec_disc,
  input  logic                 dec_stole,
  output logic [UPC_W-1:0]     sel_upc,
  output logic                 sel_mark,
  output logic                 sel_valid,
  output logic [NUM_LANES-1:0] grant,
  output logic [NUM_LANES-1:0] lane_done,
  output logic [NUM_LANES-1:0] lane_disc,
  output logic [NUM_LANES-1:0] alarm,
  output logic                 busy,
  output logic [CNT_W-1:0]     item_cnt0,
  output logic [CNT_W-1:0]     item_cnt1
);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  state_t state_q, state_d;
  logic [NUM_LANES-1:0] grant_q, grant_d, lane_disc_q, lane_disc_d, alarm_q, alarm_d;
  logic [NUM_LANES-1:0] eligible, arb_gnt;
  logic [UPC_W-1:0] sel_upc_q, sel_upc_d;
  logic sel_mark_q, sel_mark_d, sel_valid_q, sel_valid_d, advance;
  logic [HC_W-1:0] hold_q, hold_d;
  lane_t g;
  assign eligible = lane_req & ~alarm_q;
  rr_arbiter_2 u_arb (
    .clk(clk),
    .reset(reset),
    .req(eligible),
    .advance(advance),
    .gnt(arb_gnt)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_upc_d = sel_upc_q;
    sel_mark_d = sel_mark_q;
    sel_valid_d = sel_valid_q;
    hold_d = hold_q;
    lane_disc_d = lane_disc_q;
    alarm_d = alarm_q & ~alarm_ack;
    advance = 1'b0;
    g = grant_q[1];
    case (state_q)
      IDLE: if (|arb_gnt) begin
        advance = 1'b1;
        grant_d = arb_gnt;
        sel_upc_d = arb_gnt[1] ? lane_upc1 : lane_upc0;
        sel_mark_d = arb_gnt[1] ? lane_mark[1] : lane_mark[0];
        sel_valid_d = 1'b1;
        state_d = EVAL;
      end
      EVAL: begin
        lane_disc_d[g] = dec_disc;
        if (dec_stole) alarm_d[g] = 1'b1;
        hold_d = '0;
        state_d = HOLD;
      end
      HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HC_W'(HOLD_CYCLES - 1)) state_d = DONE;
      end
      default: begin
        grant_d = '0;
        sel_upc_d = '0;
        sel_mark_d = 1'b0;
        sel_valid_d = 1'b0;
        hold_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_upc_q <= '0;
      sel_mark_q <= 1'b0;
      sel_valid_q <= 1'b0;
      hold_q <= '0;
      lane_disc_q <= '0;
      alarm_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_upc_q <= sel_upc_d;
      sel_mark_q <= sel_mark_d;
      sel_valid_q <= sel_valid_d;
      hold_q <= hold_d;
      lane_disc_q <= lane_disc_d;
      alarm_q <= alarm_d;
    end
  end
  assign sel_upc = sel_upc_q;
  assign sel_mark = sel_mark_q;
  assign sel_valid = sel_valid_q;
  assign grant = grant_q;
  assign lane_done = (state_q == DONE) ? grant_q : '0;
  assign lane_disc = lane_disc_q;
  assign alarm = alarm_q;
  assign busy = (state_q != IDLE);
`ifdef UPC_ITEM_COUNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    cnt0_d = cnt0_q + CNT_W'(lane_done[0]);
    cnt1_d = cnt1_q + CNT_W'(lane_done[1]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign item_cnt0 = cnt0_q;
  assign item_cnt1 = cnt1_q;
`else
  assign item_cnt0 = '0;
  assign item_cnt1 = '0;
`endif
endmodule

// File: tb/tb_upc_lane_arbiter.sv
// tb_upc_lane_arbiter: directed scenarios plus random traffic against an item-level model
module tb_upc_lane_arbiter;
  localparam int HC = 4;
  logic clk, reset;
  logic [1:0] lane_req, lane_mark, alarm_ack, grant, lane_done, lane_disc, alarm;
  logic [2:0] lane_upc0, lane_upc1, sel_upc;
  logic dec_disc, dec_stole, sel_mark, sel_valid, busy;
  logic [1:0] item_cnt0, item_cnt1;
  int checks = 0, failures = 0;

  upc_lane_arbiter #(.HOLD_CYCLES(HC), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .lane_req(lane_req), .lane_upc0(lane_upc0),
    .lane_upc1(lane_upc1), .lane_mark(lane_mark), .alarm_ack(alarm_ack),
    .dec_disc(dec_disc), .dec_stole(dec_stole), .sel_upc(sel_upc),
    .sel_mark(sel_mark), .sel_valid(sel_valid), .grant(grant),
    .lane_done(lane_done), .lane_disc(lane_disc), .alarm(alarm), .busy(busy),
    .item_cnt0(item_cnt0), .item_cnt1(item_cnt1)
  );

  assign dec_disc = (sel_upc == 3'b011);
  assign dec_stole = (sel_upc == 3'b101) && !sel_mark;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Item-level model: an active item has an age counted from its grant cycle.
  logic m_live = 1'b0, m_active, m_mark, m_d, m_s;
  int m_age, m_lane, m_ptr, m_cnt0, m_cnt1;
  logic [1:0] m_alarm, m_disc, m_nalarm, m_elig;
  logic [2:0] m_upc;
  initial forever begin
    @(posedge clk);
    m_d = (m_upc == 3'b011);
    m_s = (m_upc == 3'b101) && !m_mark;
    if (reset) begin
      m_live = 1'b1; m_active = 1'b0; m_age = 0; m_lane = 0; m_ptr = 0;
      m_alarm = 2'b00; m_disc = 2'b00; m_upc = 3'b000; m_mark = 1'b0;
      m_cnt0 = 0; m_cnt1 = 0;
    end else if (m_live) begin
      m_nalarm = m_alarm & ~alarm_ack;
      if (m_active) begin
        if (m_age == 0) begin
          m_disc[m_lane] = m_d;
          if (m_s) m_nalarm[m_lane] = 1'b1;
        end
        if (m_age == HC + 1) begin
          if (m_lane == 0) m_cnt0 = (m_cnt0 + 1) % 4;
          else m_cnt1 = (m_cnt1 + 1) % 4;
          m_active = 1'b0; m_upc = 3'b000; m_mark = 1'b0;
        end else m_age++;
      end else begin
        m_elig = lane_req & ~m_alarm;
        if (m_elig != 2'b00) begin
          m_lane = (m_elig == 2'b11) ? m_ptr : (m_elig == 2'b10 ? 1 : 0);
          m_ptr = 1 - m_lane;
          m_active = 1'b1; m_age = 0;
          m_upc = m_lane ? lane_upc1 : lane_upc0;
          m_mark = lane_mark[m_lane];
        end
      end
      m_alarm = m_nalarm;
    end
  end

  logic [1:0] e_oh, e_cnt0, e_cnt1;
  logic [17:0] e_vec, a_vec;
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      e_oh = m_active ? (m_lane ? 2'b10 : 2'b01) : 2'b00;
`ifdef UPC_ITEM_COUNT_EN
      e_cnt0 = 2'(m_cnt0); e_cnt1 = 2'(m_cnt1);
`else
      e_cnt0 = 2'b00; e_cnt1 = 2'b00;
`endif
      e_vec = {e_oh, m_upc, m_mark, m_active, (m_active && m_age == HC + 1) ? e_oh : 2'b00,
               m_disc, m_alarm, m_active, e_cnt1, e_cnt0};
      a_vec = {grant, sel_upc, sel_mark, sel_valid, lane_done, lane_disc, alarm, busy,
               item_cnt1, item_cnt0};
      chk("model_cycle", 32'(a_vec), 32'(e_vec));
    end
  end

  task automatic do_reset();
    reset = 1'b1; lane_req = 2'b00; alarm_ack = 2'b00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 50 && g == 2'b00; i++) begin
      @(negedge clk);
      g = grant;
    end
    if (g == 2'b00) chk("wait_grant_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 0, 1);
  endtask

  logic [1:0] got [4];
  logic [1:0] prev, g1;
  logic seen1;
  int ng, seq [5];
  initial begin
    seq = '{1, 2, 3, 0, 1};
    reset = 1'b1; lane_req = 2'b00; lane_mark = 2'b00; alarm_ack = 2'b00;
    lane_upc0 = 3'b000; lane_upc1 = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_outputs", 32'({grant, sel_upc, sel_valid, lane_disc, alarm, busy}), 0);
    // single lane 0 discount item
    lane_upc0 = 3'b011; lane_req = 2'b01;
    @(negedge clk);
    chk("s1_grant", 32'(grant), 32'h1);
    chk("s1_sel_upc", 32'(sel_upc), 32'h3);
    lane_req = 2'b00;
    @(negedge clk);
    chk("s1_disc", 32'(lane_disc), 32'h1);
    repeat (3) @(negedge clk);
    chk("s1_done_early", 32'(lane_done), 0);
    @(negedge clk);
    chk("s1_done", 32'(lane_done), 32'h1);
    @(negedge clk);
    chk("s1_idle", 32'({grant, alarm, busy}), 0);
    // both lanes requesting alternate
    do_reset();
    lane_upc1 = 3'b001; lane_req = 2'b11; prev = 2'b00; ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      if (grant != 2'b00 && prev == 2'b00) begin got[ng] = grant; ng++; end
      prev = grant;
    end
    chk("s2_count", ng, 4);
    chk("s2_g0", 32'(got[0]), 32'h1);
    chk("s2_g1", 32'(got[1]), 32'h2);
    chk("s2_g2", 32'(got[2]), 32'h1);
    chk("s2_g3", 32'(got[3]), 32'h2);
    lane_req = 2'b00;
    wait_idle();
    // stolen on lane 1 blocks it until acked
    do_reset();
    lane_upc1 = 3'b101; lane_req = 2'b10;
    repeat (8) @(negedge clk);
    chk("s3_alarm_set", 32'(alarm), 32'h2);
    lane_req = 2'b11; seen1 = 1'b0;
    wait_grant(g1);
    chk("s3_first_grant", 32'(g1), 32'h1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant[1]) seen1 = 1'b1;
    end
    chk("s3_lane1_blocked", 32'(seen1), 0);
    lane_req = 2'b10;
    wait_idle();
    lane_upc1 = 3'b001; alarm_ack = 2'b10;
    @(negedge clk);
    alarm_ack = 2'b00;
    chk("s3_alarm_clr", 32'(alarm), 0);
    wait_grant(g1);
    chk("s3_lane1_grant", 32'(g1), 32'h2);
    lane_req = 2'b00;
    wait_idle();
    // set wins over simultaneous ack
    do_reset();
    lane_upc1 = 3'b101; lane_mark = 2'b00; alarm_ack = 2'b10; lane_req = 2'b10;
    repeat (2) @(negedge clk);
    chk("s4_set_wins", 32'(alarm), 32'h2);
    alarm_ack = 2'b00; lane_req = 2'b00;
    wait_idle();
    // reset during HOLD
    do_reset();
    lane_upc0 = 3'b011; lane_req = 2'b01;
    repeat (3) @(negedge clk);
    reset = 1'b1; lane_req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    chk("s5_reset_all", 32'({grant, sel_upc, sel_mark, sel_valid, lane_done, lane_disc, alarm, busy,
                              item_cnt0, item_cnt1}), 0);
    prev = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      prev = prev | lane_done;
    end
    chk("s5_no_done", 32'(prev), 0);
    // item counter wrap
    do_reset();
    lane_upc0 = 3'b001; lane_req = 2'b01;
    for (int k = 0; k < 5; k++) begin
      ng = 0;
      while (lane_done != 2'b01 && ng < 20) begin
        @(negedge clk);
        ng++;
      end
      @(negedge clk);
`ifdef UPC_ITEM_COUNT_EN
      chk("s6_cnt0", 32'(item_cnt0), 32'(seq[k]));
`else
      chk("s6_cnt0_off", 32'(item_cnt0), 32'(seq[k] * 0));
`endif
    end
    lane_req = 2'b00;
    wait_idle();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) lane_req = 2'($urandom_range(0, 3));
      lane_upc0 = 3'($urandom_range(0, 7));
      lane_upc1 = 3'($urandom_range(0, 7));
      lane_mark = 2'($urandom_range(0, 3));
      alarm_ack = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
